// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv issue sequencer: FSM encoding,
// status-register redirect constants and the default WAIT timeout.
// The MULTDIV_RSTATUS_EN build option (used by multdiv_issue_ctrl) relies on
// the RSTATUS_* constants below.
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } md_state_e;

  localparam int unsigned RSTATUS_REG  = 30;
  localparam int unsigned RSTATUS_MULT = 1;
  localparam int unsigned RSTATUS_DIV  = 2;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/multdiv_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag. tc_o rises on the
// Limit-th enabled cycle after a clear, so the owner can abort on that cycle.
module multdiv_timeout_ctr #(
  parameter int unsigned Limit = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Sequencer between execute and the multi-cycle multiply/divide unit.
// Captures a request, pulses ctrl_MULT/ctrl_DIV once, stalls until the unit
// reports ready (or times out) and then emits a one-cycle writeback.
// Build option MULTDIV_RSTATUS_EN: exceptional results are redirected to the
// status register (r30) with a code of 1 (mult) or 2 (div).
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned REG_BITS       = 5,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_valid,
  input  logic                i_is_mult,
  input  logic                i_is_div,
  input  logic [WIDTH-1:0]    i_opA,
  input  logic [WIDTH-1:0]    i_opB,
  input  logic [REG_BITS-1:0] i_rd,
  output logic                o_stall,
  output logic [WIDTH-1:0]    md_operandA,
  output logic [WIDTH-1:0]    md_operandB,
  output logic                md_ctrl_MULT,
  output logic                md_ctrl_DIV,
  input  logic [WIDTH-1:0]    md_result,
  input  logic                md_exception,
  input  logic                md_resultRDY,
  output logic                o_wb_valid,
  output logic [REG_BITS-1:0] o_wb_rd,
  output logic [WIDTH-1:0]    o_wb_data,
  output logic                o_exception
);

  md_state_e           state_q, state_d;
  logic [WIDTH-1:0]    opa_q, opa_d;
  logic [WIDTH-1:0]    opb_q, opb_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                is_mult_q, is_mult_d;
  logic [WIDTH-1:0]    res_data_q, res_data_d;
  logic                res_exc_q, res_exc_d;
  logic                accept;
  logic                timeout;

  assign accept = i_valid & (i_is_mult | i_is_div);

  // Counter is cleared during ISSUE and runs only while waiting for ready.
  multdiv_timeout_ctr #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (state_q == StIssue),
    .en_i  (state_q == StWait),
    .tc_o  (timeout)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rd_d       = rd_q;
    is_mult_d  = is_mult_q;
    res_data_d = res_data_q;
    res_exc_d  = res_exc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          opa_d     = i_opA;
          opb_d     = i_opB;
          rd_d      = i_rd;
          is_mult_d = i_is_mult;  // mult wins when both are set
          state_d   = StIssue;
        end
      end
      // Ready seen here is left over from the previous operation.
      StIssue: state_d = StWait;
      StWait: begin
        if (md_resultRDY) begin
          res_data_d = md_result;
          res_exc_d  = md_exception;
          state_d    = StDone;
        end else if (timeout) begin
          res_data_d = '0;
          res_exc_d  = 1'b1;
          state_d    = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      opa_q      <= '0;
      opb_q      <= '0;
      rd_q       <= '0;
      is_mult_q  <= 1'b0;
      res_data_q <= '0;
      res_exc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rd_q       <= rd_d;
      is_mult_q  <= is_mult_d;
      res_data_q <= res_data_d;
      res_exc_q  <= res_exc_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    o_stall      = ((state_q == StIdle) && accept) || (state_q == StIssue) ||
                   (state_q == StWait);
    md_operandA  = opa_q;
    md_operandB  = opb_q;
    md_ctrl_MULT = (state_q == StIssue) && is_mult_q;
    md_ctrl_DIV  = (state_q == StIssue) && !is_mult_q;
    o_wb_valid   = (state_q == StDone);
    o_wb_rd      = rd_q;
    o_wb_data    = res_data_q;
    o_exception  = res_exc_q;
`ifdef MULTDIV_RSTATUS_EN
    if (res_exc_q) begin
      o_wb_rd   = REG_BITS'(RSTATUS_REG);
      o_wb_data = is_mult_q ? WIDTH'(RSTATUS_MULT) : WIDTH'(RSTATUS_DIV);
    end
`endif
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl with a behavioural multdiv model. Expected
// writebacks are queued when a request is driven and matched against the
// writebacks captured by the monitor. Honours MULTDIV_RSTATUS_EN.
`timescale 1ns/1ps
module tb_multdiv_issue_ctrl;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } wb_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_valid, i_is_mult, i_is_div;
  logic [31:0] i_opA, i_opB;
  logic [4:0]  i_rd;
  logic        o_stall;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_exception;

  wb_t exp_q[$];
  wb_t obs_q[$];
  int  passed = 0;
  int  total = 0;
  int  mult_pulses = 0;
  int  div_pulses = 0;

  // multdiv model state
  int          model_lat = 4;
  bit          model_hang = 1'b0;
  bit          stale_rdy = 1'b0;
  logic        model_rdy = 1'b0;
  logic [31:0] model_res = '0;
  logic        model_exc = 1'b0;
  bit          model_busy = 1'b0;
  int          model_cnt = 0;
  logic [31:0] pend_res = '0;
  logic        pend_exc = 1'b0;

  multdiv_issue_ctrl #(
    .WIDTH          (32),
    .REG_BITS       (5),
    .TIMEOUT_CYCLES (40)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_is_mult    (i_is_mult),
    .i_is_div     (i_is_div),
    .i_opA        (i_opA),
    .i_opB        (i_opB),
    .i_rd         (i_rd),
    .o_stall      (o_stall),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .o_wb_valid   (o_wb_valid),
    .o_wb_rd      (o_wb_rd),
    .o_wb_data    (o_wb_data),
    .o_exception  (o_exception)
  );

  initial forever #5 clock = ~clock;

  // Ready is raised in cycle (pulse cycle + model_lat); a new pulse restarts it.
  always @(posedge clock) begin
    model_rdy <= 1'b0;
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      model_busy <= !model_hang;
      model_cnt  <= 2;
      if (md_ctrl_MULT) begin
        pend_res <= md_operandA * md_operandB;
        pend_exc <= 1'b0;
      end else begin
        pend_res <= (md_operandB == 32'd0) ? 32'd0 : md_operandA / md_operandB;
        pend_exc <= (md_operandB == 32'd0);
      end
    end else if (model_busy) begin
      if (model_cnt >= model_lat) begin
        model_rdy  <= 1'b1;
        model_busy <= 1'b0;
        model_res  <= pend_res;
        model_exc  <= pend_exc;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end

  assign md_resultRDY = model_rdy | stale_rdy;
  assign md_result    = model_res;
  assign md_exception = model_exc;

  // Monitor: capture writebacks and count control pulses.
  always @(negedge clock) begin
    if (o_wb_valid) obs_q.push_back('{rd: o_wb_rd, data: o_wb_data, exc: o_exception});
    if (md_ctrl_MULT) mult_pulses <= mult_pulses + 1;
    if (md_ctrl_DIV) div_pulses <= div_pulses + 1;
  end

  function automatic wb_t mk_wb(input logic [4:0] rd, input logic [31:0] data, input logic exc,
                                input bit is_mult);
`ifdef MULTDIV_RSTATUS_EN
    if (exc) return '{rd: 5'd30, data: (is_mult ? 32'd1 : 32'd2), exc: 1'b1};
`endif
    return '{rd: rd, data: data, exc: exc};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive_req(input logic m, input logic d, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    i_valid = 1'b1; i_is_mult = m; i_is_div = d; i_opA = a; i_opB = b; i_rd = rd;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_is_mult = 1'b0; i_is_div = 1'b0;
  endtask

  // Step from ISSUE until the writeback strobe; ok drops if any WAIT cycle
  // had stall low or a control pulse.
  task automatic run_until_wb(input int budget, output int cyc, output bit ok);
    cyc = -1;
    ok  = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (o_wb_valid) begin
        cyc = i;
        break;
      end
      if (!o_stall || md_ctrl_MULT || md_ctrl_DIV) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    i_opA = 32'd0; i_opB = 32'd0; i_rd = 5'd0;
    repeat (3) tick();
    total++;
    if ({o_stall, md_ctrl_MULT, md_ctrl_DIV, o_wb_valid, o_exception} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {o_stall, md_ctrl_MULT, md_ctrl_DIV, o_wb_valid, o_exception});
    else passed++;
    total++;
    if ({md_operandA, md_operandB, o_wb_data, o_wb_rd} !== 101'd0)
      $display("FAIL reset_data: opA=%h opB=%h data=%h rd=%0d want all 0",
               md_operandA, md_operandB, o_wb_data, o_wb_rd);
    else passed++;
    reset = 1'b0;
    // valid without an op type must not be accepted
    i_valid = 1'b1; i_opA = 32'd1; i_opB = 32'd2; #1;
    total++;
    if (o_stall !== 1'b0) $display("FAIL no_op_stall: got %b want 0", o_stall);
    else passed++;
    tick();
    total++;
    if ({o_stall, md_ctrl_MULT, md_ctrl_DIV} !== 3'b000)
      $display("FAIL no_op_issue: got %b want 000", {o_stall, md_ctrl_MULT, md_ctrl_DIV});
    else passed++;
    idle_inputs();
  endtask

  task automatic test_mult();
    int cyc; bit ok; int m0; wb_t got, want;
    model_lat = 32; m0 = mult_pulses;
    drive_req(1'b1, 1'b0, 32'd6, 32'd7, 5'd5);
    exp_q.push_back(mk_wb(5'd5, 32'd42, 1'b0, 1'b1));
    #1;
    total++;
    if (o_stall !== 1'b1) $display("FAIL mult_accept_stall: got %b want 1", o_stall);
    else passed++;
    tick();
    idle_inputs(); i_opA = 32'hdead; i_opB = 32'hbeef; #1;
    total++;
    if ({md_ctrl_MULT, md_ctrl_DIV, o_stall} !== 3'b101)
      $display("FAIL mult_issue: got %b want 101", {md_ctrl_MULT, md_ctrl_DIV, o_stall});
    else passed++;
    run_until_wb(100, cyc, ok);
    total++;
    if (cyc !== 33) $display("FAIL mult_latency: got %0d want 33", cyc);
    else passed++;
    total++;
    if (ok !== 1'b1) $display("FAIL mult_wait_stall: got %b want 1", ok);
    else passed++;
    total++;
    if (o_stall !== 1'b0) $display("FAIL mult_done_stall: got %b want 0", o_stall);
    else passed++;
    tick();
    total++;
    if (o_wb_valid !== 1'b0) $display("FAIL mult_wb_width: got %b want 0", o_wb_valid);
    else passed++;
    total++;
    if ((mult_pulses - m0) !== 1) $display("FAIL mult_pulses: got %0d want 1", mult_pulses - m0);
    else passed++;
    tick();
    total++;
    if ({md_operandA, md_operandB} !== {32'd6, 32'd7})
      $display("FAIL operand_hold: got %h/%h want 6/7", md_operandA, md_operandB);
    else passed++;
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL mult_wb: got none want one");
    else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want)
        $display("FAIL mult_wb: got rd=%0d data=%0d exc=%b want rd=%0d data=%0d exc=%b",
                 got.rd, got.data, got.exc, want.rd, want.data, want.exc);
      else passed++;
    end
  endtask

  task automatic test_div_by_zero();
    int cyc; bit ok; wb_t got, want;
    model_lat = 6;
    drive_req(1'b0, 1'b1, 32'd3, 32'd0, 5'd9);
    exp_q.push_back(mk_wb(5'd9, 32'd0, 1'b1, 1'b0));
    tick();
    idle_inputs(); #1;
    total++;
    if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b01)
      $display("FAIL div0_issue: got %b want 01", {md_ctrl_MULT, md_ctrl_DIV});
    else passed++;
    run_until_wb(100, cyc, ok);
    total++;
    if (cyc !== 7 || ok !== 1'b1) $display("FAIL div0_latency: got %0d ok=%b want 7 ok=1", cyc, ok);
    else passed++;
    tick();
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL div0_wb: got none want one");
    else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want)
        $display("FAIL div0_wb: got rd=%0d data=%0d exc=%b want rd=%0d data=%0d exc=%b",
                 got.rd, got.data, got.exc, want.rd, want.data, want.exc);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int cyc; bit ok; wb_t got, want;
    // Unit never answers: forced abort after 40 WAIT cycles.
    model_hang = 1'b1;
    drive_req(1'b0, 1'b1, 32'd9, 32'd3, 5'd6);
    exp_q.push_back(mk_wb(5'd6, 32'd0, 1'b1, 1'b0));
    tick();
    idle_inputs();
    run_until_wb(100, cyc, ok);
    total++;
    if (cyc !== 41 || ok !== 1'b1) $display("FAIL timeout_len: got %0d ok=%b want 41 ok=1", cyc, ok);
    else passed++;
    tick();
    total++;
    if ({o_wb_valid, o_stall} !== 2'b00)
      $display("FAIL timeout_idle: got %b want 00", {o_wb_valid, o_stall});
    else passed++;
    model_hang = 1'b0;
    // Ready arriving on the final WAIT cycle beats the timeout.
    model_lat = 40;
    drive_req(1'b1, 1'b0, 32'd3, 32'd4, 5'd8);
    exp_q.push_back(mk_wb(5'd8, 32'd12, 1'b0, 1'b1));
    tick();
    idle_inputs();
    run_until_wb(100, cyc, ok);
    total++;
    if (cyc !== 41) $display("FAIL tie_len: got %0d want 41", cyc);
    else passed++;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL timeout_wb%0d: got none", k);
      else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL timeout_wb%0d: got rd=%0d data=%0d exc=%b want rd=%0d data=%0d exc=%b",
                   k, got.rd, got.data, got.exc, want.rd, want.data, want.exc);
        else passed++;
      end
    end
  endtask

  task automatic test_stale_ready();
    int cyc; bit ok; wb_t got, want;
    model_lat = 5;
    stale_rdy = 1'b1;
    drive_req(1'b1, 1'b0, 32'd12, 32'd12, 5'd1);
    exp_q.push_back(mk_wb(5'd1, 32'd144, 1'b0, 1'b1));
    tick();  // ISSUE with ready still high
    idle_inputs();
    tick();  // first WAIT cycle
    stale_rdy = 1'b0; #1;
    total++;
    if ({o_wb_valid, o_stall} !== 2'b01)
      $display("FAIL stale_ignored: got %b want 01", {o_wb_valid, o_stall});
    else passed++;
    run_until_wb(100, cyc, ok);
    total++;
    if (cyc !== 5) $display("FAIL stale_latency: got %0d want 5", cyc);
    else passed++;
    tick();
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL stale_wb: got none want one");
    else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want)
        $display("FAIL stale_wb: got rd=%0d data=%0d exc=%b want rd=%0d data=%0d exc=%b",
                 got.rd, got.data, got.exc, want.rd, want.data, want.exc);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc; bit ok; int n0; bit quiet; wb_t got, want;
    model_lat = 32;
    drive_req(1'b0, 1'b1, 32'd20, 32'd3, 5'd11);
    tick();
    idle_inputs();
    repeat (10) tick();  // WAIT cycle 10
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    total++;
    if ({o_stall, md_ctrl_MULT, md_ctrl_DIV, o_wb_valid} !== 4'b0000)
      $display("FAIL midreset_outputs: got %b want 0000",
               {o_stall, md_ctrl_MULT, md_ctrl_DIV, o_wb_valid});
    else passed++;
    // The aborted op's late ready must not produce a writeback.
    n0 = obs_q.size(); quiet = 1'b1;
    repeat (25) begin
      tick();
      if (o_stall || o_wb_valid) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1 || obs_q.size() !== n0)
      $display("FAIL midreset_quiet: got quiet=%b wbs=%0d want quiet=1 wbs=%0d",
               quiet, obs_q.size(), n0);
    else passed++;
    model_lat = 8;
    drive_req(1'b0, 1'b1, 32'd100, 32'd7, 5'd12);
    exp_q.push_back(mk_wb(5'd12, 32'd14, 1'b0, 1'b0));
    tick();
    idle_inputs();
    run_until_wb(100, cyc, ok);
    total++;
    if (cyc !== 9) $display("FAIL postreset_latency: got %0d want 9", cyc);
    else passed++;
    tick();
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL postreset_wb: got none want one");
    else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want)
        $display("FAIL postreset_wb: got rd=%0d data=%0d exc=%b want rd=%0d data=%0d exc=%b",
                 got.rd, got.data, got.exc, want.rd, want.data, want.exc);
      else passed++;
    end
  endtask

  task automatic test_both_set();
    int cyc; bit ok; wb_t got, want;
    model_lat = 3;
    drive_req(1'b1, 1'b1, 32'd5, 32'd8, 5'd0);  // rd=0 still written back
    exp_q.push_back(mk_wb(5'd0, 32'd40, 1'b0, 1'b1));
    tick();
    idle_inputs(); #1;
    total++;
    if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b10)
      $display("FAIL both_mult_wins: got %b want 10", {md_ctrl_MULT, md_ctrl_DIV});
    else passed++;
    run_until_wb(50, cyc, ok);
    tick();
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL both_wb: got none want one");
    else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want)
        $display("FAIL both_wb: got rd=%0d data=%0d exc=%b want rd=%0d data=%0d exc=%b",
                 got.rd, got.data, got.exc, want.rd, want.data, want.exc);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; wb_t got, want;
    model_lat = 4;
    drive_req(1'b1, 1'b0, 32'd9, 32'd11, 5'd3);
    exp_q.push_back(mk_wb(5'd3, 32'd99, 1'b0, 1'b1));
    tick();
    // Next request presented immediately and held.
    drive_req(1'b0, 1'b1, 32'd50, 32'd5, 5'd4);
    exp_q.push_back(mk_wb(5'd4, 32'd10, 1'b0, 1'b0));
    run_until_wb(50, cyc, ok);
    #1;
    total++;
    if (cyc !== 5 || o_stall !== 1'b0)
      $display("FAIL b2b_done: got cyc=%0d stall=%b want cyc=5 stall=0", cyc, o_stall);
    else passed++;
    model_lat = 6;
    tick();
    total++;
    if ({o_wb_valid, o_stall, md_ctrl_DIV} !== 3'b010)
      $display("FAIL b2b_accept: got %b want 010", {o_wb_valid, o_stall, md_ctrl_DIV});
    else passed++;
    tick();
    idle_inputs(); #1;
    total++;
    if ({md_ctrl_MULT, md_ctrl_DIV, md_operandA} !== {2'b01, 32'd50})
      $display("FAIL b2b_issue: got %b opA=%0d want 01 opA=50",
               {md_ctrl_MULT, md_ctrl_DIV}, md_operandA);
    else passed++;
    run_until_wb(50, cyc, ok);
    total++;
    if (cyc !== 7) $display("FAIL b2b_latency: got %0d want 7", cyc);
    else passed++;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL b2b_wb%0d: got none", k);
      else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL b2b_wb%0d: got rd=%0d data=%0d exc=%b want rd=%0d data=%0d exc=%b",
                   k, got.rd, got.data, got.exc, want.rd, want.data, want.exc);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_by_zero();
    test_timeout();
    test_stale_ready();
    test_reset_mid_op();
    test_both_set();
    test_back_to_back();
    total++;
    if (obs_q.size() !== 0 || exp_q.size() !== 0)
      $display("FAIL leftover: got obs=%0d exp=%0d want 0/0", obs_q.size(), exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
